// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// ntt_pkg : shared modulus defaults, butterfly state encoding and the
//           modular add/sub/double/halve helpers used by the NTT datapath.
// Revision: 1.0
// ============================================================================
package ntt_pkg;

    localparam int unsigned c_q_default = 32'd1068564481;
    localparam int unsigned c_w_default = $clog2(c_q_default);
    localparam int unsigned c_word_w    = 32;

    typedef logic [c_word_w-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        HALVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operands are zero-extended into word_t; one spare bit holds the carry.
    function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
        logic [c_word_w:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, q}) begin
            t = t - {1'b0, q};
        end
        return t[c_word_w-1:0];
    endfunction

    function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
        logic [c_word_w:0] t;
        t = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            t = t + {1'b0, q};
        end
        return t[c_word_w-1:0];
    endfunction

    function automatic word_t mod_dbl(input word_t a, input word_t q);
        logic [c_word_w:0] t;
        t = {a, 1'b0};
        if (t >= {1'b0, q}) begin
            t = t - {1'b0, q};
        end
        return t[c_word_w-1:0];
    endfunction

    // Multiplies by 2^-1 mod q for odd q: odd values borrow q before shifting.
    function automatic word_t mod_half(input word_t v, input word_t q);
        logic [c_word_w:0] t;
        t = v[0] ? ({1'b0, v} + {1'b0, q}) : {1'b0, v};
        return word_t'(t >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gs_butterfly_mod_mul_serial.sv
`default_nettype none
// ============================================================================
// mod_mul_serial : bit-serial interleaved modular multiplier, p = d*w mod Q.
//                  Scans w MSB-first, one double-and-add step per cycle.
// Revision: 1.0
// ============================================================================
module mod_mul_serial
    import ntt_pkg::*;
#(
    parameter int unsigned Q = c_q_default,
    parameter int unsigned W = $clog2(Q)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] d,
    input  logic [W-1:0] w,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned     c_iw      = (W > 1) ? $clog2(W) : 1;
    localparam word_t           c_q       = word_t'(Q);
    localparam logic [c_iw-1:0] c_idx_top = c_iw'(W - 1);

    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_d;
    logic [W-1:0]    r_w;
    logic [c_iw-1:0] r_idx;
    logic            r_busy;
    logic            r_done;

    logic [W-1:0]    w_dbl;
    logic [W-1:0]    w_next;

    assign w_dbl  = W'(mod_dbl(word_t'(r_acc), c_q));
    assign w_next = r_w[r_idx] ? W'(mod_add(word_t'(w_dbl), word_t'(r_d), c_q)) : w_dbl;

    // done is a single-cycle pulse; p holds until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_d    <= '0;
            r_w    <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc  <= '0;
                r_d    <= d;
                r_w    <= w;
                r_idx  <= c_idx_top;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= w_next;
                if (r_idx == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx - c_iw'(1);
                end
            end
        end
    end

    assign done = r_done;
    assign p    = r_acc;

endmodule
`default_nettype wire

// File: rtl/gs_butterfly.sv
`default_nettype none
// ============================================================================
// gs_butterfly : iterative Gentleman-Sande butterfly for the inverse NTT,
//                x = (a+b) mod Q, y = (a-b)*w mod Q. Define
//                GS_BUTTERFLY_HALVE_EN to scale both outputs by 2^-1 mod Q.
// Revision: 1.0
// ============================================================================
module gs_butterfly
    import ntt_pkg::*;
#(
    parameter int unsigned Q = c_q_default,
    parameter int unsigned W = $clog2(Q)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam word_t c_q = word_t'(Q);

    state_t       r_state;
    logic [W-1:0] r_s;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;

    logic [W-1:0] w_s;
    logic [W-1:0] w_d;
    logic [W-1:0] w_p;
    logic         w_start;
    logic         w_mul_done;

    assign w_s     = W'(mod_add(word_t'(a), word_t'(b), c_q));
    assign w_d     = W'(mod_sub(word_t'(a), word_t'(b), c_q));
    assign w_start = (r_state == IDLE) && in_valid;

    mod_mul_serial #(
        .Q (Q),
        .W (W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .d     (w_d),
        .w     (w),
        .done  (w_mul_done),
        .p     (w_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s     <= w_s;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_x <= r_s;
                        r_y <= w_p;
`ifdef GS_BUTTERFLY_HALVE_EN
                        r_state <= HALVE;
`else
                        r_state <= DONE;
`endif
                    end
                end
`ifdef GS_BUTTERFLY_HALVE_EN
                HALVE: begin
                    r_x     <= W'(mod_half(word_t'(r_x), c_q));
                    r_y     <= W'(mod_half(word_t'(r_y), c_q));
                    r_state <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign x         = r_x;
    assign y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_gs_butterfly.sv
`default_nettype none
// ============================================================================
// tb_gs_butterfly : randomized and directed checks of gs_butterfly against an
//                   arithmetic reference model held in a scoreboard queue.
// Revision: 1.0
// ============================================================================
module tb_gs_butterfly;

    localparam longint unsigned Q = 64'd1068564481;
    localparam int W = 30;
`ifdef GS_BUTTERFLY_HALVE_EN
    localparam bit HALVE = 1'b1;
`else
    localparam bit HALVE = 1'b0;
`endif
    localparam int LAT = HALVE ? W + 2 : W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] w;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;

    gs_butterfly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned halve(input longint unsigned v);
        if (!HALVE) return v;
        return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
    endfunction

    function automatic logic [W-1:0] model_x(input logic [W-1:0] ia, input logic [W-1:0] ib);
        longint unsigned la = ia;
        longint unsigned lb = ib;
        return W'(halve((la + lb) % Q));
    endfunction

    function automatic logic [W-1:0] model_y(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                             input logic [W-1:0] iw);
        longint unsigned la = ia;
        longint unsigned lb = ib;
        longint unsigned lw = iw;
        longint unsigned d;
        d = (la + Q - lb) % Q;
        return W'(halve((d * lw) % Q));
    endfunction

    typedef struct {
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        int           acc_cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] prev_x;
    logic [W-1:0] prev_y;
    bit           prev_ov = 1'b0;
    bit           prev_or = 1'b0;

    // Compare process: samples on the falling edge, inputs change after rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            check("in_ready_vs_pending", in_ready, exp_q.size() == 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_valid_without_pending");
                end else begin
                    if (!prev_ov)
                        check("latency", cyc - exp_q[0].acc_cyc, LAT);
                    if (prev_ov && !prev_or) begin
                        check("stall_x_stable", x, prev_x);
                        check("stall_y_stable", y, prev_y);
                    end
                    if (out_ready) begin
                        check("model_x", x, exp_q[0].ex);
                        check("model_y", y, exp_q[0].ey);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.ex      = model_x(a, b);
                e.ey      = model_y(a, b, w);
                e.acc_cyc = cyc + 1;
                exp_q.push_back(e);
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_x  = x;
            prev_y  = y;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tw,
                         input int stall, input bit junk,
                         output logic [W-1:0] rx, output logic [W-1:0] ry);
        int n;
        tick();
        a = ta; b = tb; w = tw; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) fail_now("accept_wait");
        tick();
        a = W'($urandom); b = W'($urandom); w = W'($urandom);
        in_valid = junk;
        if (junk) repeat (3) tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        if (n >= 100) fail_now("out_valid_wait");
        repeat (stall) tick();
        rx = x;
        ry = y;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return W'(Q - 1);
            3: return W'(Q - 2);
            default: return W'($urandom_range(0, 32'(Q - 1)));
        endcase
    endfunction

    logic [W-1:0] rx, ry;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; w = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        rst_n = 1'b1;

        do_op(10, 8, 1, 0, 1'b0, rx, ry);
        check("t1_x", rx, HALVE ? 9 : 18);
        check("t1_y", ry, HALVE ? 1 : 2);

        do_op(10, 11, 1, 0, 1'b0, rx, ry);
        check("t2_x", rx, HALVE ? 534282251 : 21);
        check("t2_y", ry, HALVE ? 534282240 : 1068564480);

        do_op(W'(1068564480), W'(1068564480), W'(1068564480), 0, 1'b1, rx, ry);
        check("t3_x", rx, HALVE ? 1068564480 : 1068564479);
        check("t3_y", ry, 0);

        do_op(0, W'(1068564480), W'(1068564480), 1, 1'b0, rx, ry);
        check("t4_x", rx, HALVE ? 534282240 : 1068564480);
        check("t4_y", ry, HALVE ? 534282240 : 1068564480);

        do_op(3, 1, 5, 5, 1'b0, rx, ry);
        check("t5_x", rx, HALVE ? 2 : 4);
        check("t5_y", ry, HALVE ? 5 : 10);

        // Reset ten edges into a multiply: the pending butterfly must vanish.
        tick();
        a = 10; b = 8; w = 1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        do_op(10, 8, 1, 0, 1'b0, rx, ry);
        check("post_rst_x", rx, HALVE ? 9 : 18);
        check("post_rst_y", ry, HALVE ? 1 : 2);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb, rw;
            ra = pick(); rb = pick(); rw = pick();
            repeat ($urandom_range(0, 2)) tick();
            do_op(ra, rb, rw, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), rx, ry);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
